// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } ldr_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, start-bit
// glitch rejection, one-cycle rx_valid on a good stop bit or rx_ferr on a bad one.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        state;
  logic             rx_p0, rx_p1, rx_p2;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  // Synchronizer (rx_p0/rx_p1) plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Bit-timing state machine; data bits shift in LSB first.
  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    rx_ferr  <= 1'b0;
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_data <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_p2 && !rx_p1) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            rx_data <= {rx_p1, rx_data[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_p1) rx_valid <= 1'b1;
            else       rx_ferr  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: parses a framed image (sync, 16-bit LE length, LE words, XOR
// checksum) from the UART and writes it into instruction memory while the CPU is held.
module uart_program_loader
  import riscv_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14,
  parameter int BASE_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  loading_complete,
  output logic                  load_error
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam longint unsigned MAX_WORDS = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  ldr_state_t          state;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [ADDR_WIDTH:0] word_idx;
  logic [1:0]          byte_cnt;
  logic [31:0]         word_sh;
  logic [7:0]          csum;
  logic [15:0]         n_rx;
  logic [31:0]         word_next;

  assign n_rx      = {rx_data, len_lo};
  assign word_next = {rx_data, word_sh[31:8]};

  // Loader FSM with word assembly, running XOR checksum and registered outputs.
  always_ff @(posedge clk) begin
    mem_we <= 1'b0;
    if (rst) begin
      state            <= IDLE;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      loading_complete <= 1'b0;
      load_error       <= 1'b0;
      cpu_hold         <= 1'b1;
      len_lo           <= '0;
      len              <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      word_sh          <= '0;
      csum             <= '0;
    end else if (rx_ferr && state != DONE && state != ERROR) begin
      state      <= ERROR;
      load_error <= 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE: if (rx_data == SYNC_BYTE) state <= LEN0;
        LEN0: begin
          len_lo <= rx_data;
          state  <= LEN1;
        end
        LEN1: begin
          len <= n_rx;
          if (64'(n_rx) > MAX_WORDS) begin
            state      <= ERROR;
            load_error <= 1'b1;
          end else if (n_rx == 16'd0) begin
            state <= CSUM;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          word_sh  <= word_next;
          csum     <= csum ^ rx_data;
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == 2'(WORD_BYTES - 1)) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + word_idx[ADDR_WIDTH-1:0];
            mem_wdata <= word_next;
            word_idx  <= word_idx + 1'b1;
            if (32'(word_idx) + 32'd1 == 32'(len)) state <= CSUM;
          end
        end
        CSUM: begin
          if (rx_data == csum) begin
            state            <= DONE;
            loading_complete <= 1'b1;
            cpu_hold         <= 1'b0;
          end else begin
            state      <= ERROR;
            load_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed + randomized bench for uart_program_loader with a frame-level reference model.
module tb_uart_program_loader;

  localparam int              CPB  = 16;
  localparam int              AW   = 4;
  localparam int              BASE = 0;
  localparam longint unsigned MAXW = (64'd1 << AW) - 64'(BASE);

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [63:0] wr_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          loading_complete;
  logic          load_error;

  wr_q_t got_wr;
  int    checks = 0;
  int    passed = 0;
  logic  prev_we = 1'b0;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx         (uart_rx),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .cpu_hold        (cpu_hold),
    .loading_complete(loading_complete),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every write and flags back-to-back strobes.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_wr.push_back({32'(mem_addr), mem_wdata});
      checks++;
      assert (prev_we === 1'b0) passed++;
      else $error("FAIL we_b2b obs=1 exp=0");
    end
    prev_we = mem_we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    got_wr.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  // Reference: locate the sync byte, decode length/words/checksum by byte offsets.
  task automatic model(input byte_q_t f, output wr_q_t exp_wr, output logic exp_done,
                       output logic exp_err);
    int         s;
    int         n;
    logic [7:0] x;
    logic [31:0] word;
    exp_wr = {};
    exp_done = 1'b0;
    exp_err = 1'b0;
    x = 8'h00;
    s = 0;
    while (s < f.size() && f[s] != 8'hA5) s++;
    n = {f[s+2], f[s+1]};
    if (longint'(n) > longint'(MAXW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      word = {f[s+6+4*w], f[s+5+4*w], f[s+4+4*w], f[s+3+4*w]};
      x = x ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
      exp_wr.push_back({32'((BASE + w) % (1 << AW)), word});
    end
    if (f[s+3+4*n] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic check_result(input string tag, input byte_q_t f);
    wr_q_t ew;
    logic  ed, ee;
    repeat (20) @(negedge clk);
    model(f, ew, ed, ee);
    check({tag, "_nwr"}, 64'(got_wr.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < got_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_wr[i], ew[i]);
    check({tag, "_done"}, 64'(loading_complete), 64'(ed));
    check({tag, "_err"},  64'(load_error),       64'(ee));
    check({tag, "_hold"}, 64'(cpu_hold),         64'(!ed));
  endtask

  task automatic run_frame(input string tag, input byte_q_t f);
    do_reset(2);
    send_frame(f);
    check_result(tag, f);
  endtask

  initial begin
    byte_q_t f;
    logic [7:0] x;
    logic [7:0] b;
    int n;

    // Reset held for 5 cycles.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_hold",  64'(cpu_hold),         64'd1);
    check("rst_we",    64'(mem_we),           64'd0);
    check("rst_addr",  64'(mem_addr),         64'd0);
    check("rst_wdata", 64'(mem_wdata),        64'd0);
    check("rst_done",  64'(loading_complete), 64'd0);
    check("rst_err",   64'(load_error),       64'd0);
    rst = 1'b0;

    // Good two-word frame.
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    run_frame("good", f);

    // Same frame, wrong checksum.
    f[11] = 8'h00;
    run_frame("badsum", f);

    // Framing error on a data byte.
    do_reset(2);
    send_frame({8'hA5, 8'h01, 8'h00});
    send_byte(8'h13, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_err",  64'(load_error),       64'd1);
    check("ferr_done", 64'(loading_complete), 64'd0);
    check("ferr_hold", 64'(cpu_hold),         64'd1);
    check("ferr_nwr",  64'(got_wr.size()),    64'd0);

    // Noise ahead of an empty image.
    run_frame("noise", {8'hFF, 8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00});

    // Quarter-bit glitch while the length is expected must not become a byte.
    do_reset(2);
    send_byte(8'hA5, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_frame({8'h00, 8'h00, 8'h00});
    check_result("glitch", {8'hA5, 8'h00, 8'h00, 8'h00});

    // Reset in the middle of a word, then a fresh frame.
    do_reset(2);
    send_frame({8'hA5, 8'h01, 8'h00, 8'h13, 8'h00});
    do_reset(1);
    repeat (2) @(negedge clk);
    check("midrst_nwr",  64'(got_wr.size()),    64'd0);
    check("midrst_hold", 64'(cpu_hold),         64'd1);
    check("midrst_err",  64'(load_error),       64'd0);
    f = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame(f);
    check_result("afterrst", f);

    // Length one past the memory size.
    run_frame("toolong", {8'hA5, 8'((1 << AW) + 1), 8'h00});

    // Largest legal image with random content.
    f = {8'hA5, 8'(MAXW), 8'h00};
    x = 8'h00;
    for (int i = 0; i < 4 * int'(MAXW); i++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      f.push_back(b);
    end
    f.push_back(x);
    run_frame("maxlen", f);

    // Random frames: optional noise prefix, random words, checksum sometimes corrupted.
    for (int t = 0; t < 4; t++) begin
      f = {};
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        f.push_back(b);
      end
      n = int'($urandom_range(1, 4));
      f.push_back(8'hA5);
      f.push_back(8'(n));
      f.push_back(8'h00);
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        f.push_back(b);
      end
      if ($urandom_range(0, 1) == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
      f.push_back(x);
      run_frame($sformatf("rand%0d", t), f);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader sitting directly upstream of the RISC-V core and its instruction memory in the virtual device. It receives a framed program image over `uart_rx`, assembles little-endian 32-bit words, and writes them into instruction memory through a simple write port. While loading, it holds the CPU (`cpu_hold`). It raises `loading_complete` only after a checksum-verified image is fully written.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- `ADDR_WIDTH`, 14: memory word-address width.
- `BASE_ADDR`, 0: word address of the first program word.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address, valid with `mem_we`.
- `mem_wdata`  out  32  word data, valid with `mem_we`.
- `cpu_hold`  out  1  high until `loading_complete`; the core is held while high.
- `loading_complete`  out  1  sticky; image written and checksum matched.
- `load_error`  out  1  sticky; framing, length or checksum error.

## Operation
- **Reset values.** `mem_we`, `mem_addr` and `mem_wdata` are 0, `loading_complete` is 0, `load_error` is 0, `cpu_hold` is 1, and the FSM is in IDLE.
- **Frame format.** Sync byte 0xA5, then word count N (16-bit, little-endian, 2 bytes), then 4·N data bytes (each word little-endian), then a checksum byte. The checksum is the XOR of all 4·N data bytes.
- **RX front end.**
  - 2-flop synchronizer.
  - A falling edge in idle starts a byte; the start bit is re-checked at CLKS_PER_BIT/2. If it is high there, this is a glitch: return to idle with no byte and no error.
  - 8 data bits are sampled mid-bit.
  - The stop bit is sampled mid-bit. If it is 1, a one-cycle `rx_valid` is issued with the byte. If it is 0, a one-cycle `rx_ferr` is issued instead.
- **FSM states and transitions.**
  - IDLE → LEN0 on byte 0xA5; any other byte is ignored.
  - LEN0 → LEN1: latch the low byte of N.
  - LEN1: if N > 2^ADDR_WIDTH − BASE_ADDR → ERROR. Otherwise, N == 0 → CSUM, else → DATA.
  - DATA: shift bytes into the word register, XOR each byte into the running sum, and count bytes 0..3. On the 4th byte, write the word to `BASE_ADDR + word_idx`, then increment `word_idx`. After word N−1 is written → CSUM.
  - CSUM: byte equal to the running sum → DONE, otherwise → ERROR.
  - DONE: `loading_complete`=1, `cpu_hold`=0. Terminal until `rst`; further bytes are ignored.
  - ERROR: `load_error`=1, `cpu_hold` stays 1. Terminal until `rst`.
- `rx_ferr` in any state other than DONE or ERROR → ERROR. In IDLE, `rx_ferr` is also an error.
- **Reset mid-frame.** All state clears the same cycle and any partial word is discarded. Words already written are not rolled back.
- **Widths.** `word_idx` is ADDR_WIDTH+1 bits. The address is computed modulo 2^ADDR_WIDTH; the length check guarantees no wrap occurs.

## Timing
- Synchronizer latency is 2 cycles.
- `rx_valid` fires at the stop-bit mid-sample cycle, about 9.5·CLKS_PER_BIT + 2 cycles after the falling edge on the pin.
- `mem_we` is asserted on the cycle after the `rx_valid` of the 4th byte of a word. `mem_we` is never high on two consecutive cycles.
- `loading_complete` or `load_error` rises on the cycle after the checksum byte's `rx_valid`. `cpu_hold` falls in the same cycle as `loading_complete` rises.
- `rst` sampled high → all outputs take their reset values at that edge.

## Structure
- Package `riscv_loader_pkg` holds:
  - the FSM state enum: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR;
  - `SYNC_BYTE` = 8'hA5;
  - `WORD_BYTES` = 4.
- Sub-module `uart_rx_byte` contains the synchronizer and bit-timing counter. Its outputs are `rx_data[7:0]`, `rx_valid` and `rx_ferr`. It is reusable by the device's UART console.
- The top level contains the loader FSM, word assembly and checksum.

## Test plan
Use CLKS_PER_BIT=16 for all scenarios.
1. **Reset.** Hold `rst` 5 cycles → `cpu_hold`=1, all other outputs 0, no `mem_we`.
2. **Good frame.** Send A5 02 00 13 00 00 00 6F 00 00 00 7C → writes (0, 0x00000013) and then (1, 0x0000006F). `loading_complete`=1, `cpu_hold`=0, `load_error`=0.
3. **Bad checksum.** Send the same frame with checksum 0x00 → both words are written, `load_error`=1, `loading_complete`=0, `cpu_hold`=1.
4. **Framing error.** Send A5 01 00 13 with its stop bit driven 0 → `load_error`=1 and no `mem_we`.
5. **Noise and empty image.** Send FF 00 3C, then A5 00 00 00 → the noise is ignored, there is no `mem_we`, and `loading_complete`=1. Separately, a 0.25-bit low glitch on `uart_rx` produces no byte.
6. **Reset mid-DATA.** Pulse `rst` after A5 01 00 13 00 → no write occurs and the FSM returns to IDLE. Then send A5 01 00 EF BE AD DE 22 → (0, 0xDEADBEEF) is written and `loading_complete`=1.
